// File: rtl/comp_exp_pipe.sv
// Two-stage exponent compare / mantissa alignment for the FP adder.
// S1 picks the larger-magnitude operand and forms dexp; S2 right-shifts the min mantissa with sticky.
module comp_exp_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 28,
    localparam int unsigned OP_W = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  na,
    input  logic [OP_W-1:0]  nb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             comp,
    output logic             s_max,
    output logic             s_min,
    output logic             eff_sub,
    output logic [EXP_W-1:0] emax,
    output logic [MAN_W-1:0] mmax,
    output logic [MAN_W-1:0] malign,
    output logic [EXP_W-1:0] dexp,
    output logic             shift_sat,
    output logic             sticky
);

    localparam int unsigned CW = (EXP_W > 32) ? EXP_W : 32;

    logic             sign_a, sign_b;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W-1:0] man_a, man_b;

    assign sign_a = na[OP_W-1];
    assign sign_b = nb[OP_W-1];
    assign exp_a  = na[MAN_W +: EXP_W];
    assign exp_b  = nb[MAN_W +: EXP_W];
    assign man_a  = na[MAN_W-1:0];
    assign man_b  = nb[MAN_W-1:0];

    // Handshake
    logic v1, v2, s1_en, s2_en;

    assign s2_en    = !v2 || out_ready;
    assign s1_en    = !v1 || s2_en;
    assign in_ready = s1_en;

    // Stage 1: compare, swap, exponent difference
    logic             c_comp;
    logic             c_smax, c_smin;
    logic [EXP_W-1:0] c_emax, c_emin;
    logic [MAN_W-1:0] c_mmax, c_mmin;

    always_comb begin
        c_comp = (exp_a > exp_b) || ((exp_a == exp_b) && (man_a >= man_b));
        if (c_comp) begin
            c_smax = sign_a;
            c_smin = sign_b;
            c_emax = exp_a;
            c_emin = exp_b;
            c_mmax = man_a;
            c_mmin = man_b;
        end else begin
            c_smax = sign_b;
            c_smin = sign_a;
            c_emax = exp_b;
            c_emin = exp_a;
            c_mmax = man_b;
            c_mmin = man_a;
        end
    end

    logic             s1_comp, s1_smax, s1_smin;
    logic [EXP_W-1:0] s1_emax, s1_dexp;
    logic [MAN_W-1:0] s1_mmax, s1_mmin;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            s1_comp <= 1'b0;
            s1_smax <= 1'b0;
            s1_smin <= 1'b0;
            s1_emax <= '0;
            s1_dexp <= '0;
            s1_mmax <= '0;
            s1_mmin <= '0;
        end else if (s1_en) begin
            v1      <= in_valid;
            s1_comp <= c_comp;
            s1_smax <= c_smax;
            s1_smin <= c_smin;
            s1_emax <= c_emax;
            s1_dexp <= c_emax - c_emin;
            s1_mmax <= c_mmax;
            s1_mmin <= c_mmin;
        end
    end

    // Stage 2 combinational align; shifting by >= MAN_W naturally yields zero and a full mask
    logic [CW-1:0]    dexp_wide;
    logic             c_sat;
    logic [MAN_W-1:0] c_shifted, c_lost;
    logic             c_sticky;

    always_comb begin
        dexp_wide = CW'(s1_dexp);
        c_sat     = dexp_wide >= CW'(MAN_W);
        c_shifted = s1_mmin >> s1_dexp;
        c_lost    = s1_mmin & ~({MAN_W{1'b1}} << s1_dexp);
        c_sticky  = |c_lost;
        if (c_sat) begin
            c_shifted = '0;
            c_sticky  = |s1_mmin;
        end
    end

    logic             s2_comp, s2_smax, s2_smin, s2_sat, s2_sticky;
    logic [EXP_W-1:0] s2_emax, s2_dexp;
    logic [MAN_W-1:0] s2_mmax, s2_malign;

    always_ff @(posedge clk) begin
        if (rst) begin
            v2        <= 1'b0;
            s2_comp   <= 1'b0;
            s2_smax   <= 1'b0;
            s2_smin   <= 1'b0;
            s2_sat    <= 1'b0;
            s2_sticky <= 1'b0;
            s2_emax   <= '0;
            s2_dexp   <= '0;
            s2_mmax   <= '0;
            s2_malign <= '0;
        end else if (s2_en) begin
            v2        <= v1;
            s2_comp   <= s1_comp;
            s2_smax   <= s1_smax;
            s2_smin   <= s1_smin;
            s2_sat    <= c_sat;
            s2_sticky <= c_sticky;
            s2_emax   <= s1_emax;
            s2_dexp   <= s1_dexp;
            s2_mmax   <= s1_mmax;
            s2_malign <= {c_shifted[MAN_W-1:1], c_shifted[0] | c_sticky};
        end
    end

    assign out_valid = v2;
    assign comp      = s2_comp;
    assign s_max     = s2_smax;
    assign s_min     = s2_smin;
    assign eff_sub   = s2_smax ^ s2_smin;
    assign emax      = s2_emax;
    assign mmax      = s2_mmax;
    assign malign    = s2_malign;
    assign dexp      = s2_dexp;
    assign shift_sat = s2_sat;
    assign sticky    = s2_sticky;

endmodule

// File: tb/tb_comp_exp_pipe.sv
// Directed bench for comp_exp_pipe: alignment vectors, swap, backpressure and mid-stream reset.
module tb_comp_exp_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [36:0] na, nb;
    logic        comp, s_max, s_min, eff_sub, shift_sat, sticky;
    logic [7:0]  emax, dexp;
    logic [27:0] mmax, malign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    comp_exp_pipe #(.EXP_W(8), .MAN_W(28)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .na        (na),
        .nb        (nb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .comp      (comp),
        .s_max     (s_max),
        .s_min     (s_min),
        .eff_sub   (eff_sub),
        .emax      (emax),
        .mmax      (mmax),
        .malign    (malign),
        .dexp      (dexp),
        .shift_sat (shift_sat),
        .sticky    (sticky)
    );

    function automatic logic [36:0] mk(input logic s, input logic [7:0] e, input logic [27:0] m);
        return {s, e, m};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one pair with out_ready=1, then confirm out_valid appears exactly two edges later.
    task automatic send_one(input logic [36:0] a, input logic [36:0] b);
        na = a;
        nb = b;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1 check("acc_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("lat1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat2_valid", 64'(out_valid), 64'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_fields"},
              64'({comp, s_max, s_min, eff_sub, shift_sat, sticky, emax, dexp}), 64'd0);
        check({tag, "_mant"}, 64'({mmax, malign}), 64'd0);
    endtask

    initial begin
        int sent, recv, prev_mmax;
        logic prev_stall;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        na = '0;
        nb = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check_zero_outputs("reset");

        // Basic align
        send_one(mk(0, 8'h82, 28'h8000000), mk(0, 8'h80, 28'h8000000));
        check("basic_comp", 64'(comp), 64'd1);
        check("basic_dexp", 64'(dexp), 64'd2);
        check("basic_malign", 64'(malign), 64'h2000000);
        check("basic_sticky", 64'(sticky), 64'd0);
        check("basic_emax", 64'(emax), 64'h82);

        // Sticky jam
        send_one(mk(0, 8'h82, 28'h8000000), mk(0, 8'h80, 28'h8000003));
        check("jam_sticky", 64'(sticky), 64'd1);
        check("jam_malign", 64'(malign), 64'h2000001);

        // Saturation, dexp = 30
        send_one(mk(0, 8'h9E, 28'h8000000), mk(0, 8'h80, 28'h0000010));
        check("sat_dexp", 64'(dexp), 64'd30);
        check("sat_flag", 64'(shift_sat), 64'd1);
        check("sat_malign", 64'(malign), 64'h1);
        check("sat_sticky", 64'(sticky), 64'd1);

        // dexp = MAN_W-1: one bit survives, not saturated
        send_one(mk(0, 8'h9B, 28'h8000000), mk(0, 8'h80, 28'hFFFFFFF));
        check("d27_sat", 64'(shift_sat), 64'd0);
        check("d27_malign", 64'(malign), 64'h1);
        check("d27_sticky", 64'(sticky), 64'd1);

        // dexp = MAN_W exactly
        send_one(mk(0, 8'h9C, 28'h8000000), mk(0, 8'h80, 28'h8000000));
        check("d28_sat", 64'(shift_sat), 64'd1);
        check("d28_malign", 64'(malign), 64'h1);

        // Swap on equal exponent
        send_one(mk(0, 8'h80, 28'h4000000), mk(1, 8'h80, 28'h6000000));
        check("swap_comp", 64'(comp), 64'd0);
        check("swap_mmax", 64'(mmax), 64'h6000000);
        check("swap_signs", 64'({s_max, s_min, eff_sub}), 64'b101);
        check("swap_dexp", 64'(dexp), 64'd0);
        check("swap_malign", 64'(malign), 64'h4000000);

        // B larger exponent
        send_one(mk(1, 8'h80, 28'h0000001), mk(0, 8'h81, 28'h0000003));
        check("bmax_comp", 64'(comp), 64'd0);
        check("bmax_emax", 64'(emax), 64'h81);
        check("bmax_malign", 64'({malign, sticky}), 64'h3);

        // Identical operands tie to A
        send_one(mk(0, 8'h85, 28'h1234567), mk(0, 8'h85, 28'h1234567));
        check("tie_comp", 64'(comp), 64'd1);
        check("tie_malign", 64'(malign), 64'h1234567);

        // Backpressure: 5 pairs, out_ready low for the first 4 cycles
        @(negedge clk);
        sent = 0;
        recv = 0;
        prev_stall = 1'b0;
        prev_mmax = 0;
        for (int cyc = 0; cyc < 30 && recv < 5; cyc++) begin
            out_ready = (cyc >= 4);
            in_valid = (sent < 5);
            na = mk(0, 8'h80, 28'(sent + 1));
            nb = mk(1, 8'h80, 28'h0);
            #1;
            if (cyc < 2) check("bp_ready_high", 64'(in_ready), 64'd1);
            if (cyc == 2) check("bp_ready_low", 64'(in_ready), 64'd0);
            if (prev_stall) check("bp_hold", 64'(mmax), 64'(prev_mmax));
            if (out_valid && out_ready) begin
                check("bp_order", 64'(mmax), 64'(recv + 1));
                recv++;
            end
            prev_stall = out_valid && !out_ready;
            prev_mmax = int'(mmax);
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        check("bp_count", 64'(recv), 64'd5);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1 check("bp_drained", 64'(out_valid), 64'd0);

        // Reset with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1;
        na = mk(1, 8'h90, 28'hFFFFFFF);
        nb = mk(0, 8'h80, 28'h0000055);
        repeat (2) @(negedge clk);
        #1 check("full_state", 64'({out_valid, in_ready}), 64'b10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1 check_zero_outputs("midrst");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 check("midrst_novalid", 64'(out_valid), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
